// File: rtl/ble_cmd_seq.sv
// rtl/ble_cmd_seq.sv - scripted UART command sequencer; optional tx_done watchdog via `define CMD_SEQ_TIMEOUT_EN
module ble_cmd_seq #(
  parameter int DEPTH   = 8,
  parameter int DLY_W   = 24,
  parameter int TMO_CYC = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_cmd,
  input  logic [DLY_W-1:0] wr_dly,
  input  logic             clr,
  input  logic             go,
  input  logic             abort,
  input  logic             tx_done,
  output logic             trmt,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic             ovfl,
  output logic             err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DLY,
    S_SEND,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [7:0]       cmd_mem [DEPTH];
  logic [DLY_W-1:0] dly_mem [DEPTH];

  logic [CW-1:0]    count_q;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    idx_nxt;
  logic [DLY_W-1:0] dly_cnt_q;

  logic             trmt_q;
  logic [7:0]       tx_data_q;
  logic             busy_q;
  logic             done_q;
  logic             ovfl_q;
  logic             err_q;

  logic             clr_ok;
  logic             wr_ok;
  logic             wr_drop;
  logic             last_entry;
  logic             start_play;
  logic             next_entry;
  logic             tmo_hit;

  // A clear only counts in IDLE, and it beats a simultaneous write without flagging overflow.
  assign clr_ok     = clr && (state_q == S_IDLE);
  assign wr_ok      = wr_en && !clr && (state_q == S_IDLE) && (count_q != CW'(DEPTH));
  assign wr_drop    = wr_en && !clr_ok && !wr_ok;
  assign idx_nxt    = idx_q + 1'b1;
  assign last_entry = ({1'b0, idx_q} == (count_q - 1'b1));

`ifdef CMD_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q == S_WAIT_DONE) && !tx_done && (tmo_cnt_q == TW'(TMO_CYC - 1));

  // Watchdog counts cycles spent in WAIT_DONE; it restarts from zero on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q != S_WAIT_DONE) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  // No watchdog in this build: the comparison is constant false for any legal TMO_CYC.
  assign tmo_hit = (TMO_CYC < 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort overrides everything and suppresses datapath loads.
  always_comb begin
    state_d    = state_q;
    start_play = 1'b0;
    next_entry = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            if (count_q != '0) begin
              state_d    = S_WAIT_DLY;
              start_play = 1'b1;
            end else begin
              state_d = S_FINISH;
            end
          end
        end
        S_WAIT_DLY: begin
          if (dly_cnt_q == '0) begin
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            if (last_entry) begin
              state_d = S_FINISH;
            end else begin
              state_d    = S_WAIT_DLY;
              next_entry = 1'b1;
            end
          end else if (tmo_hit) begin
            state_d = S_IDLE;
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Script storage; entries survive reset and playback, only count decides validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      cmd_mem[count_q[AW-1:0]] <= wr_cmd;
      dly_mem[count_q[AW-1:0]] <= wr_dly;
    end
  end

  // Entry count, playback index and the pre-send delay counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      idx_q     <= '0;
      dly_cnt_q <= '0;
    end else begin
      if (clr_ok) begin
        count_q <= '0;
      end else if (wr_ok) begin
        count_q <= count_q + 1'b1;
      end
      if (start_play) begin
        idx_q     <= '0;
        dly_cnt_q <= dly_mem[0];
      end else if (next_entry) begin
        idx_q     <= idx_nxt;
        dly_cnt_q <= dly_mem[idx_nxt];
      end else if ((state_q == S_WAIT_DLY) && (dly_cnt_q != '0)) begin
        dly_cnt_q <= dly_cnt_q - 1'b1;
      end
    end
  end

  // Registered outputs follow the state one cycle later; an abort cancels a pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovfl_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      trmt_q <= (state_q == S_SEND) && !abort;
      done_q <= (state_q == S_FINISH) && !abort;
      busy_q <= (state_q != S_IDLE);
      if (state_q == S_SEND) begin
        tx_data_q <= cmd_mem[idx_q];
      end
      if (wr_drop) begin
        ovfl_q <= 1'b1;
      end
      if (tmo_hit && !abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign trmt    = trmt_q;
  assign tx_data = tx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovfl    = ovfl_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ble_cmd_seq.sv
// tb/tb_ble_cmd_seq.sv - scoreboard bench for ble_cmd_seq with a queue-based script model
module tb_ble_cmd_seq;

  localparam int DEPTH = 8;
  localparam int DLY_W = 24;
  localparam int TMO   = 50;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [7:0]       wr_cmd;
  logic [DLY_W-1:0] wr_dly;
  logic             clr;
  logic             go;
  logic             abort;
  logic             tx_done;
  logic             trmt;
  logic [7:0]       tx_data;
  logic             busy;
  logic             done;
  logic             ovfl;
  logic             err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
  } tx_exp_t;

  tx_exp_t    exp_tx[$];
  int         exp_done[$];
  int         lat_q[$];
  logic [7:0] scmd[$];
  int         sdly[$];
  bit         movfl;

  ble_cmd_seq #(.DEPTH(DEPTH), .DLY_W(DLY_W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_dly(wr_dly),
    .clr(clr), .go(go), .abort(abort), .tx_done(tx_done),
    .trmt(trmt), .tx_data(tx_data), .busy(busy), .done(done), .ovfl(ovfl), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses trmt or done.
  always @(negedge clk) begin : monitor
    tx_exp_t e;
    int      dc;
    if (trmt === 1'b1) begin
      if (exp_tx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL trmt_unexpected: trmt at cycle %0d data %0d, none required", cyc, tx_data);
      end else begin
        e = exp_tx.pop_front();
        chk("trmt_cycle", cyc, e.c);
        chk("tx_data", tx_data, e.d);
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: done at cycle %0d, none required", cyc);
      end else begin
        dc = exp_done.pop_front();
        chk("done_cycle", cyc, dc);
      end
    end
  end

  // UART stand-in: answers each trmt with a tx_done sampled L edges later (L=0 withholds it).
  initial begin : responder
    int l;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (trmt === 1'b1 && lat_q.size() > 0) begin
        l = lat_q.pop_front();
        if (l > 0) begin
          repeat (l - 1) @(negedge clk);
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic write_entry(input logic [7:0] c, input int d);
    wr_en  = 1'b1;
    wr_cmd = c;
    wr_dly = DLY_W'(d);
    @(negedge clk);
    wr_en = 1'b0;
    if (scmd.size() < DEPTH) begin
      scmd.push_back(c);
      sdly.push_back(d);
    end else begin
      movfl = 1'b1;
    end
  endtask

  task automatic clear_script();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    scmd.delete();
    sdly.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    movfl = 1'b0;
    scmd.delete();
    sdly.delete();
  endtask

  task automatic finish_checks();
    chk("trmt_missing", exp_tx.size(), 0);
    chk("done_missing", exp_done.size(), 0);
    exp_tx.delete();
    exp_done.delete();
    lat_q.delete();
  endtask

  // Plays the modelled script: first byte at go+dly+2, later bytes at tx_done+dly+2,
  // done one cycle after the final tx_done (or after go for an empty script).
  task automatic play(input int fixed_lat, input bit poke);
    int      g;
    int      t;
    int      tl;
    int      l;
    tx_exp_t e;
    go = 1'b1;
    g  = cyc + 1;
    @(negedge clk);
    go = 1'b0;
    tl = g;
    t  = 0;
    for (int i = 0; i < scmd.size(); i++) begin
      t   = (i == 0) ? (g + sdly[0] + 2) : (tl + sdly[i] + 2);
      l   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(8, 1));
      e.c = t;
      e.d = scmd[i];
      exp_tx.push_back(e);
      lat_q.push_back(l);
      tl  = t + l;
    end
    exp_done.push_back(tl + 1);
    if (poke) begin
      wait_until(g + 3);
      go     = 1'b1;
      wr_en  = 1'b1;
      wr_cmd = 8'hEE;
      wr_dly = '0;
      @(negedge clk);
      go    = 1'b0;
      wr_en = 1'b0;
      movfl = 1'b1;
    end
    wait_until(tl + 1);
    chk("busy_at_done", busy, 1);
    wait_until(tl + 2);
    chk("busy_after_done", busy, 0);
    chk("ovfl", ovfl, movfl);
    chk("err", err, 0);
    finish_checks();
  endtask

  initial begin : stim
    int      g;
    int      n;
    tx_exp_t e;
    rst = 1'b1; wr_en = 1'b0; clr = 1'b0; go = 1'b0; abort = 1'b0;
    wr_cmd = 8'h00; wr_dly = '0; movfl = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trmt", trmt, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovfl", ovfl, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte, zero delay.
    write_entry(8'h47, 0);
    play(0, 1'b0);

    // clr together with wr_en: script emptied, write dropped silently.
    clr = 1'b1; wr_en = 1'b1; wr_cmd = 8'h99; wr_dly = '0;
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0;
    scmd.delete(); sdly.delete();
    chk("clr_wr_ovfl", ovfl, 0);
    play(0, 1'b0);

    // Two entries with fixed 20-cycle tx_done; go and a write while busy are ignored/dropped.
    write_entry(8'h47, 100);
    write_entry(8'h53, 5);
    play(20, 1'b1);

    // Random scripts, sometimes replayed.
    for (int it = 0; it < 6; it++) begin
      clear_script();
      n = int'($urandom_range(DEPTH, 1));
      for (int k = 0; k < n; k++) write_entry(8'($urandom_range(255, 0)), int'($urandom_range(20, 0)));
      play(0, 1'b0);
      if ($urandom_range(1, 0) == 1) play(0, 1'b0);
    end

    // Overflow: ninth write dropped, exactly DEPTH bytes played; clr then go gives bare done.
    do_reset();
    for (int k = 0; k < DEPTH; k++) write_entry(8'(8'h30 + k), k % 3);
    chk("ovfl_full", ovfl, 0);
    write_entry(8'hFF, 1);
    chk("ovfl_ninth", ovfl, 1);
    play(0, 1'b0);
    clear_script();
    play(0, 1'b0);

    // Abort during WAIT_DLY of entry 1 of 3, then a full replay.
    clear_script();
    write_entry(8'h11, 30);
    write_entry(8'h22, 30);
    write_entry(8'h33, 30);
    go = 1'b1; g = cyc + 1;
    @(negedge clk);
    go = 1'b0;
    e.c = g + 32; e.d = 8'h11;
    exp_tx.push_back(e);
    lat_q.push_back(3);
    wait_until(g + 40);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_until(g + 100);
    chk("abort_busy", busy, 0);
    finish_checks();
    play(0, 1'b0);

    // abort together with go in IDLE: nothing starts.
    go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_go_busy", busy, 0);
    finish_checks();

    // Withheld tx_done.
    clear_script();
    write_entry(8'h5A, 0);
    go = 1'b1; g = cyc + 1;
    @(negedge clk);
    go = 1'b0;
    e.c = g + 2; e.d = 8'h5A;
    exp_tx.push_back(e);
    lat_q.push_back(0);
`ifdef CMD_SEQ_TIMEOUT_EN
    wait_until(g + 2 + TMO + 10);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
`else
    wait_until(g + 300);
    chk("hold_busy", busy, 1);
    chk("hold_err", err, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_abort_busy", busy, 0);
`endif
    finish_checks();

    // Reset for one cycle during WAIT_DONE; the late tx_done must be ignored.
    clear_script();
    write_entry(8'hA5, 2);
    go = 1'b1; g = cyc + 1;
    @(negedge clk);
    go = 1'b0;
    e.c = g + 4; e.d = 8'hA5;
    exp_tx.push_back(e);
    lat_q.push_back(40);
    wait_until(g + 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_trmt", trmt, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovfl", ovfl, 0);
    chk("mid_rst_err", err, 0);
    movfl = 1'b0;
    scmd.delete(); sdly.delete();
    wait_until(g + 60);
    finish_checks();
    play(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
